// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Brief    : 8N1 UART receiver front end with mid-bit sampling and break detect.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [2:0]            state_rx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  logic                  sync1_q;
  logic                  rx_s_q;
  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [BIT_W-1:0]      bitn_q,   bitn_d;
  logic [DATA_WIDTH-1:0] sh_q,     sh_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  ferr_q,   ferr_d;
  logic                  busy_q,   busy_d;

  // Synchroniser idles high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= ext_data_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        cnt_d = cnt_q + C_CNT_ONE;
        // A start bit that is gone by mid-bit was a glitch.
        if (cnt_q == C_HALF_M1) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + C_CNT_ONE;
        if (cnt_q == C_FULL_M1) begin
          sh_d  = {rx_s_q, sh_q[DATA_WIDTH-1:1]};
          cnt_d = '0;
          if (bitn_q == C_LAST_BIT) state_d = ST_STOP;
          else                      bitn_d  = bitn_q + C_BIT_ONE;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + C_CNT_ONE;
        if (cnt_q == C_FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign state_rx  = state_q;

endmodule
`default_nettype wire
